// File: rtl/gd_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gd_pkg : Q24.8 constants and controller state encoding.                  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package gd_pkg;
   localparam int Q_WIDTH   = 32;
   localparam int Q_FRAC    = 8;
   localparam int Y_WIDTH   = 64;
   localparam int IDX_WIDTH = 8;
   localparam logic [Q_WIDTH-1:0] Q_ONE = 32'h0000_0100;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_LAUNCH,
      ST_WAIT_DONE,
      ST_CAPTURE,
      ST_RELEASE,
      ST_FINISH
   } gd_state_t;
endpackage
`default_nettype wire

// File: rtl/gd_sweep_controller_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gd_sweep_controller_if : start/done handshake to the gradient core.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface gd_sweep_controller_if;
   import gd_pkg::*;

   logic                 core_start_op;
   logic [Q_WIDTH-1:0]   core_x_init;
   logic                 core_done_op;
   logic [Q_WIDTH-1:0]   core_x_at_min;
   logic [Y_WIDTH-1:0]   core_y_min;

   modport master (
      output core_start_op, core_x_init,
      input  core_done_op, core_x_at_min, core_y_min
   );

   modport slave (
      input  core_start_op, core_x_init,
      output core_done_op, core_x_at_min, core_y_min
   );
endinterface
`default_nettype wire

// File: rtl/gd_min_tracker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gd_min_tracker : running minimum of y (signed) with its x and index.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module gd_min_tracker
   import gd_pkg::*;
(
   input  wire logic                  clk,
   input  wire logic                  rst_n,
   input  wire logic                  load,
   input  wire logic                  first,
   input  wire logic [Q_WIDTH-1:0]    x,
   input  wire logic [Y_WIDTH-1:0]    y,
   input  wire logic [IDX_WIDTH-1:0]  index,
   output logic      [Q_WIDTH-1:0]    best_x,
   output logic      [Y_WIDTH-1:0]    best_y,
   output logic      [IDX_WIDTH-1:0]  best_index
);
   logic [Q_WIDTH-1:0]   r_best_x;
   logic [Y_WIDTH-1:0]   r_best_y;
   logic [IDX_WIDTH-1:0] r_best_index;
   logic                 w_take;

   // Strict less-than: an equal y never displaces the earlier run.
   assign w_take = load && (first || ($signed(y) < $signed(r_best_y)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_best_x     <= '0;
         r_best_y     <= '0;
         r_best_index <= '0;
      end else if (w_take) begin
         r_best_x     <= x;
         r_best_y     <= y;
         r_best_index <= index;
      end
   end

   assign best_x     = r_best_x;
   assign best_y     = r_best_y;
   assign best_index = r_best_index;
endmodule
`default_nettype wire

// File: rtl/gd_sweep_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gd_sweep_controller : runs the gradient core LOOP_COUNT times from a     |
// | stepped x_init and reports per-run and best results. Revision: 1.0       |
// +--------------------------------------------------------------------------+
module gd_sweep_controller
   import gd_pkg::*;
#(
   parameter int                 LOOP_COUNT     = 4,
   parameter logic [Q_WIDTH-1:0] INCREMENT      = Q_ONE,
   parameter int                 TIMEOUT_CYCLES = 65535
) (
   input  wire logic                  clk,
   input  wire logic                  rst_n,
   input  wire logic                  sweep_start,
   input  wire logic [Q_WIDTH-1:0]    x_start,
   gd_sweep_controller_if.master      core,
   output logic                       run_valid,
   output logic      [IDX_WIDTH-1:0]  run_index,
   output logic      [Q_WIDTH-1:0]    run_x,
   output logic      [Y_WIDTH-1:0]    run_y,
   output logic      [Q_WIDTH-1:0]    best_x,
   output logic      [Y_WIDTH-1:0]    best_y,
   output logic      [IDX_WIDTH-1:0]  best_index,
   output logic                       busy,
   output logic                       sweep_done,
   output logic                       timeout
);
   localparam int                   WD_W     = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WD_W-1:0]      WD_LOAD  = WD_W'(TIMEOUT_CYCLES);
   localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(LOOP_COUNT - 1);

   gd_state_t            r_state;
   logic                 r_start;
   logic [Q_WIDTH-1:0]   r_x_init;
   logic [IDX_WIDTH-1:0] r_count;
   logic [WD_W-1:0]      r_wdog;
   logic                 r_run_valid;
   logic [IDX_WIDTH-1:0] r_run_index;
   logic [Q_WIDTH-1:0]   r_run_x;
   logic [Y_WIDTH-1:0]   r_run_y;
   logic                 r_busy;
   logic                 r_sweep_done;
   logic                 r_timeout;
   logic                 w_capture;

   // Results are registered on the same edge that sees done, giving one cycle to run_valid.
   assign w_capture = (r_state == ST_WAIT_DONE) && core.core_done_op;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_start      <= 1'b0;
         r_x_init     <= '0;
         r_count      <= '0;
         r_wdog       <= '0;
         r_run_valid  <= 1'b0;
         r_run_index  <= '0;
         r_run_x      <= '0;
         r_run_y      <= '0;
         r_busy       <= 1'b0;
         r_sweep_done <= 1'b0;
         r_timeout    <= 1'b0;
      end else begin
         r_run_valid  <= 1'b0;
         r_sweep_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (sweep_start) begin
                  r_x_init  <= x_start;
                  r_count   <= '0;
                  r_timeout <= 1'b0;
                  r_busy    <= 1'b1;
                  r_state   <= ST_CLEAR;
               end
            end
            ST_CLEAR: begin
               if (!core.core_done_op) begin
                  r_start <= 1'b1;
                  r_state <= ST_LAUNCH;
               end
            end
            ST_LAUNCH: begin
               r_wdog  <= WD_LOAD;
               r_state <= ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
               if (core.core_done_op) begin
                  r_run_x     <= core.core_x_at_min;
                  r_run_y     <= core.core_y_min;
                  r_run_index <= r_count;
                  r_run_valid <= 1'b1;
                  r_start     <= 1'b0;
                  r_state     <= ST_CAPTURE;
               end else if (r_wdog <= WD_W'(1)) begin
                  r_timeout    <= 1'b1;
                  r_start      <= 1'b0;
                  r_sweep_done <= 1'b1;
                  r_busy       <= 1'b0;
                  r_state      <= ST_FINISH;
               end else begin
                  r_wdog <= r_wdog - WD_W'(1);
               end
            end
            ST_CAPTURE: begin
               r_state <= ST_RELEASE;
            end
            ST_RELEASE: begin
               if (!core.core_done_op) begin
                  if (r_count == LAST_IDX) begin
                     r_sweep_done <= 1'b1;
                     r_busy       <= 1'b0;
                     r_state      <= ST_FINISH;
                  end else begin
                     r_count  <= r_count + IDX_WIDTH'(1);
                     r_x_init <= r_x_init + INCREMENT;
                     r_start  <= 1'b1;
                     r_state  <= ST_LAUNCH;
                  end
               end
            end
            ST_FINISH: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   gd_min_tracker u_min_tracker (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (w_capture),
      .first      (r_count == '0),
      .x          (core.core_x_at_min),
      .y          (core.core_y_min),
      .index      (r_count),
      .best_x     (best_x),
      .best_y     (best_y),
      .best_index (best_index)
   );

   assign core.core_start_op = r_start;
   assign core.core_x_init   = r_x_init;
   assign run_valid          = r_run_valid;
   assign run_index          = r_run_index;
   assign run_x              = r_run_x;
   assign run_y              = r_run_y;
   assign busy               = r_busy;
   assign sweep_done         = r_sweep_done;
   assign timeout            = r_timeout;
endmodule
`default_nettype wire

// File: tb/tb_gd_sweep_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_gd_sweep_controller : scoreboard bench with a behavioural core model. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_gd_sweep_controller;
   localparam int          LC  = 4;
   localparam logic [31:0] INC = 32'h0000_0100;
   localparam int          TO  = 20;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sweep_start = 1'b0;
   logic [31:0] x_start = '0;
   logic        run_valid, busy, sweep_done, timeout;
   logic [7:0]  run_index, best_index;
   logic [31:0] run_x, best_x;
   logic [63:0] run_y, best_y;

   gd_sweep_controller_if cif ();

   gd_sweep_controller #(
      .LOOP_COUNT     (LC),
      .INCREMENT      (INC),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .sweep_start (sweep_start),
      .x_start     (x_start),
      .core        (cif),
      .run_valid   (run_valid),
      .run_index   (run_index),
      .run_x       (run_x),
      .run_y       (run_y),
      .best_x      (best_x),
      .best_y      (best_y),
      .best_index  (best_index),
      .busy        (busy),
      .sweep_done  (sweep_done),
      .timeout     (timeout)
   );

   always #5 clk = ~clk;

   // Core model: done 5 cycles after start rises, drops once start falls.
   function automatic logic [63:0] model_y(input logic [31:0] x);
      longint d;
      d = longint'(signed'(x)) - 64'sd256;
      return 64'(d * d);
   endfunction

   bit   hang = 1'b0;
   bit   force_done = 1'b0;
   int   m_cnt = 0;
   logic m_done = 1'b0;

   always @(posedge clk) begin
      if (cif.core_start_op) m_cnt <= m_cnt + 1;
      else                   m_cnt <= 0;
      m_done <= force_done || (cif.core_start_op && !hang && m_cnt >= 4);
   end

   assign cif.core_done_op  = m_done;
   assign cif.core_x_at_min = cif.core_x_init;
   assign cif.core_y_min    = model_y(cif.core_x_init);

   typedef struct {
      logic [7:0]  idx;
      logic [31:0] x;
      logic [63:0] y;
      logic [31:0] bx;
      logic [63:0] by;
      logic [7:0]  bi;
   } run_t;

   run_t exp_runs[$];
   bit   exp_done[$];
   int   n_checks = 0;
   int   n_err = 0;
   int   n_runs = 0;
   int   n_done = 0;
   int   cyc = 0;
   int   launch_cyc = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, req);
      end
   endtask

   // Expected results of one sweep, straight from the stepping and min rules.
   task automatic push_sweep(input logic [31:0] xs, input bit to);
      logic [31:0] x;
      logic [63:0] y;
      longint      by;
      logic [31:0] bx;
      int          bi;
      by = 0; bx = '0; bi = 0;
      if (!to) begin
         for (int i = 0; i < LC; i++) begin
            x = xs + 32'(i) * INC;
            y = model_y(x);
            if (i == 0 || longint'(y) < by) begin
               by = longint'(y);
               bx = x;
               bi = i;
            end
            exp_runs.push_back('{8'(i), x, y, bx, 64'(by), 8'(bi)});
         end
      end
      exp_done.push_back(to);
   endtask

   initial begin : monitor
      logic d1, d2, s1;
      run_t e;
      bit   et;
      d1 = 1'b0; d2 = 1'b0; s1 = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst_n) begin
            if (cif.core_start_op && !s1) launch_cyc = cyc;
            if (run_valid) begin
               n_runs++;
               chk("run_latency", {62'd0, d2, d1}, 64'd1);
               chk("busy_in_run", busy, 1);
               if (exp_runs.size() == 0) begin
                  n_checks++;
                  n_err++;
                  $display("FAIL unexpected_run_valid: got run_index %0d required none", run_index);
               end else begin
                  e = exp_runs.pop_front();
                  chk("run_index", run_index, e.idx);
                  chk("run_x", run_x, e.x);
                  chk("run_y", run_y, e.y);
                  chk("best_x", best_x, e.bx);
                  chk("best_y", best_y, e.by);
                  chk("best_index", best_index, e.bi);
               end
            end
            if (sweep_done) begin
               n_done++;
               chk("busy_at_done", busy, 0);
               if (exp_done.size() == 0) begin
                  n_checks++;
                  n_err++;
                  $display("FAIL unexpected_sweep_done: got 1 required 0");
               end else begin
                  et = exp_done.pop_front();
                  chk("sweep_timeout", timeout, et);
                  if (et) chk("timeout_latency", 64'(cyc - launch_cyc), 64'(TO + 1));
               end
            end
         end
         d2 = d1;
         d1 = cif.core_done_op;
         s1 = cif.core_start_op;
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_busy();
      int k = 0;
      while (!busy && k < 20) begin tick(); k++; end
      chk("wait_busy", busy, 1);
   endtask

   task automatic wait_done(input int target);
      int k = 0;
      while (n_done < target && k < 400) begin tick(); k++; end
      chk("wait_sweep_done", 64'(n_done >= target), 1);
   endtask

   task automatic run_sweep(input logic [31:0] xs, input bit to, input int hold);
      int target;
      x_start = xs;
      push_sweep(xs, to);
      target = n_done + 1;
      sweep_start = 1'b1;
      wait_busy();
      x_start = $urandom;
      repeat (hold) tick();
      sweep_start = 1'b0;
      wait_done(target);
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, "_flags"}, {59'd0, busy, cif.core_start_op, run_valid, sweep_done, timeout}, 0);
      chk({nm, "_x_init"}, cif.core_x_init, 0);
      chk({nm, "_run"}, {run_index, run_x} | run_y, 0);
      chk({nm, "_best"}, {best_index, best_x} | best_y, 0);
   endtask

   initial begin : stimulus
      int target, k, base;
      bit saw;
      logic [31:0] xs;

      repeat (3) tick();
      chk_all_zero("reset");

      // First sweep is raised together with reset release.
      x_start = 32'hFFFF_FE00;
      push_sweep(x_start, 1'b0);
      rst_n = 1'b1;
      sweep_start = 1'b1;
      tick();
      chk("accept_after_reset", busy, 1);
      sweep_start = 1'b0;
      wait_done(1);
      chk("dir_best_x", best_x, 32'h0000_0100);
      chk("dir_best_y", best_y, 0);
      chk("dir_best_index", best_index, 3);
      chk("dir_one_done", n_done, 1);

      run_sweep(32'h7FFF_FF00, 1'b0, 2);

      for (int i = 0; i < 5; i++) run_sweep($urandom, 1'b0, $urandom_range(0, 6));

      // Stale done from the core must hold off the first launch.
      force_done = 1'b1;
      tick(); tick();
      xs = $urandom;
      x_start = xs;
      push_sweep(xs, 1'b0);
      target = n_done + 1;
      sweep_start = 1'b1;
      wait_busy();
      sweep_start = 1'b0;
      saw = 1'b0;
      repeat (8) begin tick(); if (cif.core_start_op) saw = 1'b1; end
      chk("stale_done_no_start", saw, 0);
      force_done = 1'b0;
      wait_done(target);

      hang = 1'b1;
      run_sweep($urandom, 1'b1, 2);
      hang = 1'b0;
      chk("timeout_sticky", timeout, 1);
      run_sweep($urandom, 1'b0, 1);

      // sweep_start held across FINISH restarts after one idle cycle.
      xs = $urandom;
      x_start = xs;
      push_sweep(xs, 1'b0);
      push_sweep(xs, 1'b0);
      target = n_done + 1;
      sweep_start = 1'b1;
      wait_busy();
      wait_done(target);
      tick();
      chk("idle_gap_busy", busy, 0);
      tick();
      chk("restart_busy", busy, 1);
      sweep_start = 1'b0;
      wait_done(target + 1);

      // Reset while waiting on the third run.
      xs = $urandom;
      x_start = xs;
      push_sweep(xs, 1'b0);
      base = n_runs;
      sweep_start = 1'b1;
      wait_busy();
      sweep_start = 1'b0;
      k = 0;
      while (n_runs < base + 2 && k < 200) begin tick(); k++; end
      k = 0;
      while (!cif.core_start_op && k < 20) begin tick(); k++; end
      chk("reached_run2_launch", cif.core_start_op, 1);
      tick(); tick();
      rst_n = 1'b0;
      #1;
      chk_all_zero("midsweep_reset");
      exp_runs.delete();
      exp_done.delete();
      tick(); tick();
      rst_n = 1'b1;
      tick();
      run_sweep($urandom, 1'b0, 0);

      repeat (3) tick();
      chk("queues_drained", 64'(exp_runs.size() + exp_done.size()), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin : global_guard
      #500000;
      $display("FAIL global_timeout: got no finish required finish");
      $fatal(1, "simulation time limit");
   end
endmodule
`default_nettype wire
